// File: rtl/age_grant_ctrl.sv
// Age-ordered packet arbiter: the oldest requester wins, starved ports override
// age order, and the grant stays locked to its owner until the tail flit or an abort.
`ifndef TIME_WIDTH
// Normally provided by global.vh; fallback keeps the block self-contained.
`define TIME_WIDTH 8
`endif

module age_grant_ctrl #(
   parameter int NPORT      = 4,
   parameter int IDX_W      = 2,
   parameter int STARVE_MAX = 15
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NPORT-1:0]              req,
   input  logic [NPORT*`TIME_WIDTH-1:0]  age,
   input  logic [NPORT-1:0]              last,
   input  logic                          out_ready,
   output logic [NPORT-1:0]              grant,
   output logic [IDX_W-1:0]              grant_idx,
   output logic                          grant_valid,
   output logic                          xfer
);

   localparam int TW    = `TIME_WIDTH;
   localparam int CNT_W = 4;
   localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

   typedef enum logic {
      IDLE = 1'b0,
      LOCK = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [NPORT-1:0]   grant_q, grant_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [CNT_W-1:0]   wait_cnt_q [NPORT];
   logic [CNT_W-1:0]   wait_cnt_d [NPORT];

   logic [NPORT-1:0]   starved;
   logic [IDX_W-1:0]   win_idx;
   logic               win_hit;
   logic [TW-1:0]      best_age;
   logic               owner_req;
   logic               arb;

   // Saturating wait-counter increment.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
      if (cnt >= STARVE_LIM) return STARVE_LIM;
      return cnt + CNT_W'(1);
   endfunction

   // Pairwise arb cell: the incumbent keeps the slot unless the challenger is strictly older.
   function automatic logic challenger_wins(input logic          inc_valid,
                                            input logic [TW-1:0] inc_age,
                                            input logic          ch_req,
                                            input logic [TW-1:0] ch_age);
      return ch_req && (!inc_valid || (ch_age < inc_age));
   endfunction

   always_comb begin
      starved  = '0;
      win_idx  = '0;
      win_hit  = 1'b0;
      best_age = '0;
      for (int p = 0; p < NPORT; p++) begin
         starved[p] = req[p] && (wait_cnt_q[p] == STARVE_LIM);
      end
      if (|starved) begin
         // Walk downward so the lowest starved index is assigned last.
         for (int p = NPORT - 1; p >= 0; p--) begin
            if (starved[p]) win_idx = IDX_W'(p);
         end
      end else begin
         for (int p = 0; p < NPORT; p++) begin
            if (challenger_wins(win_hit, best_age, req[p], age[p*TW +: TW])) begin
               win_hit  = 1'b1;
               best_age = age[p*TW +: TW];
               win_idx  = IDX_W'(p);
            end
         end
      end
   end

   assign owner_req   = req[idx_q];
   assign grant       = grant_q;
   assign grant_idx   = idx_q;
   assign grant_valid = |grant_q;
   assign xfer        = grant_valid & owner_req & out_ready;
   assign arb         = (state_q == IDLE) && (|req) && out_ready;

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      idx_d      = idx_q;
      wait_cnt_d = wait_cnt_q;
      case (state_q)
         IDLE: begin
            if (arb) begin
               state_d = LOCK;
               grant_d = NPORT'(1) << win_idx;
               idx_d   = win_idx;
               for (int p = 0; p < NPORT; p++) begin
                  if (IDX_W'(p) == win_idx) wait_cnt_d[p] = '0;
                  else if (req[p])          wait_cnt_d[p] = sat_inc(wait_cnt_q[p]);
               end
            end
         end
         LOCK: begin
            // Owner dropping its request aborts; a tail flit transfer releases.
            if (!owner_req || (xfer && last[idx_q])) begin
               state_d = IDLE;
               grant_d = '0;
               idx_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
            idx_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         grant_q <= '0;
         idx_q   <= '0;
         for (int p = 0; p < NPORT; p++) wait_cnt_q[p] <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         idx_q   <= idx_d;
         for (int p = 0; p < NPORT; p++) wait_cnt_q[p] <= wait_cnt_d[p];
      end
   end

endmodule

// File: tb/tb_age_grant_ctrl.sv
// Directed bench for age_grant_ctrl: expected grants are queued by the stimulus
// and popped by a monitor on each rising grant_valid.
`ifndef TIME_WIDTH
`define TIME_WIDTH 8
`endif

module tb_age_grant_ctrl;

   localparam int NPORT = 4;
   localparam int IDX_W = 2;
   localparam int TW    = `TIME_WIDTH;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [NPORT-1:0]      req;
   logic [NPORT*TW-1:0]   age;
   logic [NPORT-1:0]      last;
   logic                  out_ready;
   logic [NPORT-1:0]      grant;
   logic [IDX_W-1:0]      grant_idx;
   logic                  grant_valid;
   logic                  xfer;

   int checks   = 0;
   int failures = 0;
   logic [5:0] exp_q [$];
   logic       prev_valid = 1'b0;

   age_grant_ctrl #(.NPORT(NPORT), .IDX_W(IDX_W), .STARVE_MAX(15)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req),
      .age        (age),
      .last       (last),
      .out_ready  (out_ready),
      .grant      (grant),
      .grant_idx  (grant_idx),
      .grant_valid(grant_valid),
      .xfer       (xfer)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_age(input int p, input int v);
      age[p*TW +: TW] = TW'(v);
   endtask

   task automatic expect_grant(input logic [3:0] g, input logic [1:0] idx);
      exp_q.push_back({g, idx});
   endtask

   // Monitor: every new grant must match the next queued expectation.
   always @(negedge clk) begin
      if (grant_valid && !prev_valid) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_grant: got grant=%b idx=%0d expected none", grant, grant_idx);
         end else begin
            if ({grant, grant_idx} !== exp_q[0]) begin
               failures++;
               $display("FAIL grant_order: got grant=%b idx=%0d expected grant=%b idx=%0d",
                        grant, grant_idx, exp_q[0][5:2], exp_q[0][1:0]);
            end
            void'(exp_q.pop_front());
         end
      end
      prev_valid <= grant_valid;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0; req = '0; age = '0; last = '0; out_ready = 1'b0;
      repeat (2) tick();
      chk("reset_grant", grant, 0);
      chk("reset_idx", grant_idx, 0);
      chk("reset_valid", grant_valid, 0);
      chk("reset_xfer", xfer, 0);
      rst_n = 1'b1;
      tick();

      // Oldest requester wins with one-cycle latency; then owner drops req.
      set_age(1, 5); set_age(2, 3); req = 4'b0110; out_ready = 1'b1;
      expect_grant(4'b0100, 2'd2);
      tick();
      chk("t1_grant", grant, 4'b0100);
      chk("t1_idx", grant_idx, 2);
      chk("t1_valid", grant_valid, 1);
      req = '0;
      #1;
      chk("abort_no_xfer", xfer, 0);
      tick();
      chk("abort_grant", grant, 0);
      chk("abort_valid", grant_valid, 0);
      chk("abort_idx", grant_idx, 0);

      // Equal ages: lower index wins.
      set_age(0, 7); set_age(1, 7); req = 4'b0011;
      expect_grant(4'b0001, 2'd0);
      tick();
      chk("tie_grant", grant, 4'b0001);
      req = '0;
      tick();
      chk("tie_release", grant_valid, 0);

      // Three-flit packet, release on tail, re-arbitration after one idle cycle.
      set_age(2, 9); req = 4'b0100; last = '0;
      expect_grant(4'b0100, 2'd2);
      tick();
      chk("pkt_xfer1", xfer, 1);
      chk("pkt_grant1", grant, 4'b0100);
      tick();
      chk("pkt_xfer2", xfer, 1);
      chk("pkt_grant2", grant, 4'b0100);
      tick();
      last = 4'b0100;
      #1;
      chk("pkt_xfer3", xfer, 1);
      chk("pkt_grant3", grant, 4'b0100);
      expect_grant(4'b0100, 2'd2);
      tick();
      last = '0;
      chk("pkt_released", grant, 0);
      chk("pkt_released_valid", grant_valid, 0);
      tick();
      chk("pkt_rearb", grant, 4'b0100);
      req = '0;
      tick();
      chk("pkt_rearb_abort", grant_valid, 0);

      // out_ready low in IDLE holds; all-ones age still granted; non-owner activity ignored.
      out_ready = 1'b0; req = 4'b1000; age[3*TW +: TW] = '1;
      tick();
      chk("idle_hold1", grant_valid, 0);
      tick();
      chk("idle_hold2", grant_valid, 0);
      expect_grant(4'b1000, 2'd3);
      out_ready = 1'b1;
      tick();
      chk("allones_grant", grant, 4'b1000);
      out_ready = 1'b0; req = 4'b1001; set_age(0, 0);
      #1;
      chk("lock_stall_xfer", xfer, 0);
      tick();
      chk("lock_nonowner_grant", grant, 4'b1000);
      chk("lock_nonowner_idx", grant_idx, 3);
      set_age(1, 0); req = 4'b1011;
      tick();
      chk("lock_nonowner_grant2", grant, 4'b1000);
      req = 4'b0001; out_ready = 1'b1;
      expect_grant(4'b0001, 2'd0);
      tick();
      chk("abort_pending_clear", grant_valid, 0);
      tick();
      chk("abort_pending_rearb", grant, 4'b0001);
      req = '0;
      tick();

      // Asynchronous reset in the middle of a locked packet.
      req = 4'b0010; set_age(1, 4);
      expect_grant(4'b0010, 2'd1);
      tick();
      chk("mid_lock_valid", grant_valid, 1);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_grant", grant, 0);
      chk("async_rst_idx", grant_idx, 0);
      chk("async_rst_valid", grant_valid, 0);
      chk("async_rst_xfer", xfer, 0);

      // Starvation: port 3 loses 15 times to port 0, wins the 16th, then loses again.
      req = 4'b1001; set_age(0, 1); set_age(3, 200); last = 4'b1001; out_ready = 1'b1;
      for (int i = 0; i < 15; i++) expect_grant(4'b0001, 2'd0);
      expect_grant(4'b1000, 2'd3);
      expect_grant(4'b0001, 2'd0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("first_arb_after_reset", grant, 4'b0001);
      begin
         bit drained = 1'b0;
         for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0) begin
               drained = 1'b1;
               break;
            end
         end
         chk("starve_drain", drained, 1);
      end
      req = '0; last = '0;
      tick();
      tick();
      chk("final_idle", grant_valid, 0);
      chk("sb_empty_end", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
